// File: rtl/luma4x4_mode_sched.sv
// Intra 4x4 luma mode scheduler: walks the 16 blocks of a macroblock, sums the
// absolute residuals of eight directional modes and reports the cheapest one.
module luma4x4_mode_sched (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         pred_req,
  output logic [3:0]   blk_idx,
  input  logic         pred_valid,
  output logic         res_en,
  input  logic [127:0] vres,
  input  logic [127:0] hres,
  input  logic [127:0] vlres,
  input  logic [127:0] vrres,
  input  logic [127:0] hures,
  input  logic [127:0] hdres,
  input  logic [127:0] ddlres,
  input  logic [127:0] ddrres,
  output logic [3:0]   best_mode,
  output logic [11:0]  best_sad,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         done
);

  localparam int NMODES = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_RES,
    S_SAD,
    S_CMP,
    S_OUT
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  blk_q, blk_d;
  logic [2:0]  rank_q, rank_d;
  logic [11:0] sad_q [NMODES];
  logic [11:0] sad_d [NMODES];
  logic [3:0]  cand_mode_q, cand_mode_d;
  logic [11:0] cand_sad_q, cand_sad_d;
  logic        done_q, done_d;

  logic [127:0] res_by_rank [NMODES];
  logic [11:0]  sad_now     [NMODES];

  // Rank is the scan position in the compare phase; codes ascend with rank.
  function automatic logic [3:0] rank_to_code(input logic [2:0] rank);
    case (rank)
      3'd0:    return 4'd0;
      3'd1:    return 4'd1;
      3'd2:    return 4'd3;
      3'd3:    return 4'd4;
      3'd4:    return 4'd5;
      3'd5:    return 4'd6;
      3'd6:    return 4'd7;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [11:0] block_sad(input logic [127:0] res);
    logic [11:0] acc;
    logic [7:0]  mag;
    acc = '0;
    for (int i = 0; i < 16; i++) begin
      mag = res[8*i +: 8];
      // Negating 8'h80 yields 8'h80, read unsigned as 128.
      if (mag[7]) mag = ~mag + 8'd1;
      acc = acc + {4'd0, mag};
    end
    return acc;
  endfunction

  always_comb begin
    res_by_rank[0] = vres;
    res_by_rank[1] = hres;
    res_by_rank[2] = ddlres;
    res_by_rank[3] = ddrres;
    res_by_rank[4] = vrres;
    res_by_rank[5] = hdres;
    res_by_rank[6] = vlres;
    res_by_rank[7] = hures;
    for (int k = 0; k < NMODES; k++) sad_now[k] = block_sad(res_by_rank[k]);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: if (pred_valid) state_d = S_RES;
      S_RES:   state_d = S_SAD;
      S_SAD:   state_d = S_CMP;
      S_CMP:   if (rank_q == 3'd7) state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = (blk_q == 4'd15) ? S_IDLE : S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pred_req  = (state_q == S_FETCH);
    res_en    = (state_q == S_RES);
    out_valid = (state_q == S_OUT);
    busy      = (state_q != S_IDLE);
    blk_idx   = blk_q;
    best_mode = cand_mode_q;
    best_sad  = cand_sad_q;
    done      = done_q;
  end

  always_comb begin
    // NOTE: every variable gets a hold default first so no path infers a latch.
    blk_d       = blk_q;
    rank_d      = rank_q;
    cand_mode_d = cand_mode_q;
    cand_sad_d  = cand_sad_q;
    done_d      = 1'b0;
    for (int k = 0; k < NMODES; k++) sad_d[k] = sad_q[k];

    case (state_q)
      S_IDLE: if (start) blk_d = 4'd0;
      S_SAD: begin
        for (int k = 0; k < NMODES; k++) sad_d[k] = sad_now[k];
        rank_d = 3'd0;
      end
      S_CMP: begin
        rank_d = rank_q + 3'd1;
        // Strict compare keeps the lower code on a tie.
        if (rank_q == 3'd0 || sad_q[rank_q] < cand_sad_q) begin
          cand_mode_d = rank_to_code(rank_q);
          cand_sad_d  = sad_q[rank_q];
        end
      end
      S_OUT: if (out_ready) begin
        if (blk_q == 4'd15) begin
          blk_d  = 4'd0;
          done_d = 1'b1;
        end else begin
          blk_d = blk_q + 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blk_q       <= '0;
      rank_q      <= '0;
      cand_mode_q <= '0;
      cand_sad_q  <= '0;
      done_q      <= 1'b0;
      // NOTE: the sum bank is cleared on reset; it is only eight flops wide
      // words, not a RAM, so resetting it costs nothing structural.
      for (int k = 0; k < NMODES; k++) sad_q[k] <= '0;
    end else begin
      blk_q       <= blk_d;
      rank_q      <= rank_d;
      cand_mode_q <= cand_mode_d;
      cand_sad_q  <= cand_sad_d;
      done_q      <= done_d;
      for (int k = 0; k < NMODES; k++) sad_q[k] <= sad_d[k];
    end
  end

endmodule

// File: tb/tb_luma4x4_mode_sched.sv
// Scoreboard bench for luma4x4_mode_sched: a driver pushes model results per
// block, a negedge monitor pops them on each output handshake.
module tb_luma4x4_mode_sched;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         pred_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] vres = '0, hres = '0, vlres = '0, vrres = '0;
  logic [127:0] hures = '0, hdres = '0, ddlres = '0, ddrres = '0;
  logic         pred_req, res_en, out_valid, busy, done;
  logic [3:0]   blk_idx, best_mode;
  logic [11:0]  best_sad;

  luma4x4_mode_sched dut (
    .clk(clk), .reset(reset), .start(start), .pred_req(pred_req),
    .blk_idx(blk_idx), .pred_valid(pred_valid), .res_en(res_en),
    .vres(vres), .hres(hres), .vlres(vlres), .vrres(vrres),
    .hures(hures), .hdres(hdres), .ddlres(ddlres), .ddrres(ddrres),
    .best_mode(best_mode), .best_sad(best_sad), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int blk;
    int mode;
    int sad;
    bit last;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   res [9][16];
  int   codes [8] = '{0, 1, 3, 4, 5, 6, 7, 8};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
  endtask

  // Reference: SAD per code, then the lowest code among those at the minimum.
  function automatic exp_t model(input int b);
    exp_t e;
    int   sad [9];
    int   mn;
    mn = 1 << 20;
    foreach (codes[j]) begin
      sad[codes[j]] = 0;
      for (int i = 0; i < 16; i++)
        sad[codes[j]] += (res[codes[j]][i] < 0) ? -res[codes[j]][i] : res[codes[j]][i];
      if (sad[codes[j]] < mn) mn = sad[codes[j]];
    end
    e.mode = -1;
    for (int c = 0; c <= 8; c++)
      if (c != 2 && e.mode < 0 && sad[c] == mn) e.mode = c;
    e.sad  = mn;
    e.blk  = b;
    e.last = (b == 15);
    return e;
  endfunction

  task automatic set_pattern(input int pat);
    foreach (codes[j]) begin
      for (int i = 0; i < 16; i++) begin
        case (pat)
          0:       res[codes[j]][i] = (codes[j] == 1) ? 1 : 5;
          1:       res[codes[j]][i] = (codes[j] == 0 || codes[j] == 4) ? 2 : 3;
          2:       res[codes[j]][i] = (codes[j] == 8) ? -127 : -128;
          3:       res[codes[j]][i] = -128;
          4:       res[codes[j]][i] = int'($urandom_range(0, 255)) - 128;
          default: res[codes[j]][i] = int'($urandom_range(0, 4)) - 2;
        endcase
      end
    end
    for (int i = 0; i < 16; i++) begin
      vres[8*i +: 8]   = 8'(res[0][i]);
      hres[8*i +: 8]   = 8'(res[1][i]);
      ddlres[8*i +: 8] = 8'(res[3][i]);
      ddrres[8*i +: 8] = 8'(res[4][i]);
      vrres[8*i +: 8]  = 8'(res[5][i]);
      hdres[8*i +: 8]  = 8'(res[6][i]);
      vlres[8*i +: 8]  = 8'(res[7][i]);
      hures[8*i +: 8]  = 8'(res[8][i]);
    end
  endtask

  // Monitor: timing of res_en / out_valid / done, and scoreboard compare.
  int pv_cyc = -1, done_due = -1, res_cnt = 0;
  bit prev_ov = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      pv_cyc = -1; done_due = -1; res_cnt = 0; prev_ov = 1'b0;
    end else begin
      exp_t e;
      if (pred_req && pred_valid) pv_cyc = cyc;
      if (res_en) begin
        res_cnt++;
        check("res_en_latency", cyc, pv_cyc + 1);
      end
      if (out_valid && !prev_ov) check("out_valid_latency", cyc, pv_cyc + 11);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          fail("unexpected_output");
        end else begin
          e = sb.pop_front();
          check("blk_idx", blk_idx, e.blk);
          check("best_mode", best_mode, e.mode);
          check("best_sad", best_sad, e.sad);
          check("res_en_per_block", res_cnt, 1);
          res_cnt = 0;
          if (e.last) done_due = cyc + 1;
        end
      end
      check("done", done, (cyc == done_due) ? 1 : 0);
      if (cyc == done_due) check("busy_after_last", busy, 0);
      prev_ov = out_valid;
    end
  end

  task automatic check_reset_vals();
    check("rst_pred_req", pred_req, 0);
    check("rst_blk_idx", blk_idx, 0);
    check("rst_res_en", res_en, 0);
    check("rst_best_mode", best_mode, 0);
    check("rst_best_sad", best_sad, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
  endtask

  task automatic do_start(output int c);
    @(posedge clk); #1;
    start = 1'b1;
    c = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_block(input int b, input int pat, input int pv_delay,
                           input int rdy_delay, input bit hold20, input bit cut);
    exp_t e;
    int   n;
    n = 0;
    while (!pred_req && n < 60) begin @(posedge clk); #1; n++; end
    if (!pred_req) begin fail("pred_req_wait"); return; end
    set_pattern(pat);
    e = model(b);
    sb.push_back(e);
    repeat (pv_delay) begin @(posedge clk); #1; end
    pred_valid = 1'b1;
    @(posedge clk); #1;
    pred_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    if (cut) begin
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check_reset_vals();
      return;
    end
    // Spurious inputs while comparing must be ignored.
    pred_valid = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    pred_valid = 1'b0; start = 1'b0;
    n = 0;
    while (!out_valid && n < 30) begin @(posedge clk); #1; n++; end
    if (!out_valid) begin fail("out_valid_wait"); return; end
    if (hold20) begin
      for (int k = 0; k < 20; k++) begin
        check("hold_out_valid", out_valid, 1);
        check("hold_best_mode", best_mode, e.mode);
        check("hold_best_sad", best_sad, e.sad);
        check("hold_blk_idx", blk_idx, b);
        check("hold_res_en", res_en, 0);
        @(posedge clk); #1;
      end
    end
    repeat (rdy_delay) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int   c, n;
    exp_t e;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_vals();

    // Macroblock 1: inputs tied high, H wins every block, 193-cycle span.
    set_pattern(0);
    for (int b = 0; b < 16; b++) sb.push_back(model(b));
    pred_valid = 1'b1; out_ready = 1'b1;
    do_start(c);
    n = 0;
    while (!done && n < 300) begin @(posedge clk); #1; n++; end
    if (!done) fail("mb1_done_wait");
    else       check("mb1_span", cyc - c, 193);
    pred_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("mb1_drained", sb.size(), 0);
    check("mb1_idle_busy", busy, 0);

    // Macroblock 2: directed corner patterns, delays, backpressure, noise.
    do_start(c);
    for (int b = 0; b < 16; b++)
      run_block(b, (b < 4) ? b : 4 + int'($urandom_range(0, 1)),
                (b == 2) ? 5 : int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), b == 5, 1'b0);
    repeat (3) @(posedge clk);
    #1 check("mb2_drained", sb.size(), 0);

    // Macroblock 3: reset lands in the compare phase of block 7.
    do_start(c);
    for (int b = 0; b < 7; b++) run_block(b, 4, 0, 0, 1'b0, 1'b0);
    run_block(7, 4, 1, 0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("post_reset_busy", busy, 0);
      check("post_reset_out_valid", out_valid, 0);
    end

    // Macroblock 4: fresh start after the reset, random content.
    do_start(c);
    for (int b = 0; b < 16; b++)
      run_block(b, 4 + int'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 2)), 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 check("mb4_drained", sb.size(), 0);
    check("mb4_idle_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/luma4x4_mode_sched.md
# luma4x4_mode_sched

Sequencing controller for the intra 4x4 luma residual unit. Walks the 16 4x4 blocks of a macroblock and requests predictions for each block. Pulses the residual unit's enable, sums absolute residuals (SAD) for the eight directional modes, and emits the lowest-cost mode per block. Sits between the 4x4 predictor and the transform/mode-decision stage.

## Interface
- NMODES, 8, number of directional modes evaluated; fixed, not meant to be overridden
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; returns FSM to IDLE
- start  in  1  begin a macroblock; sampled only in IDLE
- pred_req  out  1  request prediction set for blk_idx; high throughout FETCH
- blk_idx  out  4  current 4x4 block index, 0..15, raster order
- pred_valid  in  1  predictor has all eight prediction arrays stable for blk_idx; sampled only in FETCH
- res_en  out  1  enable to residual unit; one-cycle pulse per block
- vres, hres, vlres, vrres, hures, hdres, ddlres, ddrres  in  16 x 8 signed each  residual arrays from residual unit
- best_mode  out  4  H.264 intra4x4 mode code of winner
- best_sad  out  12  SAD of winner
- out_valid  out  1  best_mode/best_sad valid
- out_ready  in  1  downstream accepts
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after block 15 is accepted

## Operation
- Mode codes: V=0, H=1, DDL=3, DDR=4, VR=5, HD=6, VL=7, HU=8; code 2 (DC) never produced.
- FSM states: IDLE, FETCH, RES, SAD, CMP, OUT.
- IDLE: start=1 -> FETCH, blk_idx=0.
- FETCH: pred_req=1; pred_valid=1 -> RES.
- RES: res_en=1 for this cycle only -> SAD.
- SAD: for each mode, sum |res[i]| over i=0..15. |x| of signed 8-bit is an unsigned 8-bit value, so |-128|=128. Register eight 12-bit sums (max 2048, no overflow). -> CMP.
- CMP: 8 cycles, one mode per cycle, scanned in ascending code order 0,1,3,4,5,6,7,8.
  - First cycle loads candidate unconditionally.
  - Later cycles replace candidate only if sad < candidate (strict), so ties keep the lower code.
  - After the 8th cycle -> OUT.
- OUT: out_valid=1 and outputs held stable until out_ready=1.
  - On handshake with blk_idx<15: blk_idx increments, -> FETCH.
  - On handshake with blk_idx=15: done=1 next cycle, blk_idx returns to 0, -> IDLE.
- start outside IDLE is ignored. pred_valid outside FETCH is ignored. out_ready outside OUT is ignored.
- Reset at any time, including mid-block: state IDLE, all sums/candidate cleared, no done pulse.

## Timing
- Reset values: pred_req=0, blk_idx=0, res_en=0, best_mode=0, best_sad=0, out_valid=0, busy=0, done=0.
- start high at cycle t in IDLE -> pred_req high from t+1.
- pred_valid sampled high at cycle t:
  - res_en high in t+1; residual unit registers at end of t+1.
  - SAD in t+2.
  - CMP t+3..t+10.
  - out_valid high from t+11.
- out_ready sampled high at cycle u in OUT:
  - out_valid low at u+1.
  - pred_req high at u+1 (next block).
  - For the final block, done=1 at u+1 and busy=0 at u+1.
- Minimum per-block period with pred_valid and out_ready tied high: 12 cycles. Full macroblock: 192 cycles plus 1 for start.
- Predictor must hold prediction arrays stable from pred_valid through the RES cycle.
- Residual arrays must be stable during the SAD cycle.
- out_valid, once high, never drops without a handshake except on reset.

## Test plan
- Reset then start; residuals all zero except hres all +1 and every other mode all +5 -> best_mode=1, best_sad=16, 16 outputs, done pulse one cycle after 16th handshake.
- Tie: vres and ddrres all +2, others all +3 -> best_mode=0, best_sad=32. Check strict compare.
- Extreme: all residuals -128 except huresidual (hures) all -127 -> best_mode=8, best_sad=2032. Also all-(-128) in every mode -> best_sad=2048, best_mode=0.
- Backpressure: hold out_ready=0 for 20 cycles in OUT -> out_valid, best_mode, best_sad, blk_idx stable. No res_en; blk_idx advances only after ready.
- pred_valid delayed 5 cycles and spurious pred_valid/start pulses in CMP -> res_en exactly one pulse per block, latency t+11 preserved, no extra blocks.
- Assert reset during CMP of block 7 -> next cycle all outputs at reset values, no done. A fresh start processes blocks 0..15 normally.
